fir_filter: RTL and testbench

- Self-stimulating FIR demonstrator with no data input.
- An internal phase counter addresses a 32-entry sine lookup table. The table produces an 8-bit unsigned (offset-binary) test tone.
- The tone is exported on data_sin and passed through an 8-tap symmetric low-pass FIR. The filtered result drives Data_Out.
- Used as a standalone filter/DSP sanity block; the bench only drives clock and reset.

---
 rtl/fir_pkg.sv | 36 +++
 rtl/fir_filter_sine_gen.sv | 27 ++
 rtl/fir_filter.sv | 59 +++++
 tb/tb_fir_filter.sv | 113 +++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants for the self-stimulating FIR demonstrator: widths,
// filter coefficients, the sine table and the tap multiply helper.
package fir_pkg;

    localparam int DATA_W    = 8;
    localparam int OUT_W     = 17;
    localparam int TAPS      = 8;
    localparam int LUT_DEPTH = 32;
    localparam int PHASE_W   = $clog2(LUT_DEPTH);
    localparam int PROD_W    = 2 * DATA_W;

    // Symmetric low-pass taps; their sum (456) keeps 255*456 inside OUT_W bits.
    localparam logic [DATA_W-1:0] C [0:TAPS-1] = '{
        8'd7, 8'd31, 8'd63, 8'd127, 8'd127, 8'd63, 8'd31, 8'd7
    };

    // round(128 + 127*sin(2*pi*k/32)), offset-binary.
    localparam logic [DATA_W-1:0] SINE_LUT [0:LUT_DEPTH-1] = '{
        8'd128, 8'd153, 8'd177, 8'd199, 8'd218, 8'd234, 8'd245, 8'd253,
        8'd255, 8'd253, 8'd245, 8'd234, 8'd218, 8'd199, 8'd177, 8'd153,
        8'd128, 8'd103, 8'd79,  8'd57,  8'd38,  8'd22,  8'd11,  8'd3,
        8'd1,   8'd3,   8'd11,  8'd22,  8'd38,  8'd57,  8'd79,  8'd103
    };

    function automatic logic [PROD_W-1:0] tap_product(
        input logic [DATA_W-1:0] sample,
        input logic [DATA_W-1:0] coef
    );
        logic [PROD_W-1:0] wide_sample;
        logic [PROD_W-1:0] wide_coef;
        wide_sample = {{DATA_W{1'b0}}, sample};
        wide_coef   = {{DATA_W{1'b0}}, coef};
        return wide_sample * wide_coef;
    endfunction

endpackage

// File: rtl/fir_filter_sine_gen.sv
// Test-tone source: free-running phase counter addressing the sine table,
// with a registered sample output.
module sine_gen
    import fir_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    output logic [DATA_W-1:0] data_sin
);

    logic [PHASE_W-1:0] phase_r;
    logic [DATA_W-1:0]  data_sin_r;

    // Phase advance (wraps naturally at LUT_DEPTH) and registered table lookup.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase_r    <= {PHASE_W{1'b0}};
            data_sin_r <= {DATA_W{1'b0}};
        end else begin
            phase_r    <= phase_r + {{(PHASE_W-1){1'b0}}, 1'b1};
            data_sin_r <= SINE_LUT[phase_r];
        end
    end

    assign data_sin = data_sin_r;

endmodule

// File: rtl/fir_filter.sv
// 8-tap symmetric low-pass FIR fed by an internal sine generator; the
// delay line and a three-level adder tree feed the registered output.
module fir_filter
    import fir_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    output logic [DATA_W-1:0] data_sin,
    output logic [OUT_W-1:0]  Data_Out
);

    logic [DATA_W-1:0] sin_s;
    logic [DATA_W-1:0] x_r [0:TAPS-1];
    logic [PROD_W-1:0] prod_s [0:TAPS-1];
    logic [OUT_W-1:0]  sum_l1_s [0:3];
    logic [OUT_W-1:0]  sum_l2_s [0:1];
    logic [OUT_W-1:0]  sum_s;
    logic [OUT_W-1:0]  data_out_r;

    sine_gen u_sine_gen (
        .clock    (clock),
        .reset    (reset),
        .data_sin (sin_s)
    );

    // Tap products and adder tree over the pre-edge delay line contents.
    always_comb begin
        for (int i = 0; i < TAPS; i++) begin
            prod_s[i] = tap_product(x_r[i], C[i]);
        end
        for (int i = 0; i < 4; i++) begin
            sum_l1_s[i] = {1'b0, prod_s[2*i]} + {1'b0, prod_s[2*i+1]};
        end
        for (int i = 0; i < 2; i++) begin
            sum_l2_s[i] = sum_l1_s[2*i] + sum_l1_s[2*i+1];
        end
        sum_s = sum_l2_s[0] + sum_l2_s[1];
    end

    // Delay line shift and output register; reset clears every stage at once.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                x_r[i] <= {DATA_W{1'b0}};
            end
            data_out_r <= {OUT_W{1'b0}};
        end else begin
            x_r[0] <= sin_s;
            for (int i = 1; i < TAPS; i++) begin
                x_r[i] <= x_r[i-1];
            end
            data_out_r <= sum_s;
        end
    end

    assign data_sin = sin_s;
    assign Data_Out = data_out_r;

endmodule

// File: tb/tb_fir_filter.sv
// Directed bench for fir_filter: reset hold, release sequence, fill latency,
// golden-model tracking, periodicity, mid-run reset and a long run.
module tb_fir_filter;

    logic        clock;
    logic        reset;
    logic [7:0]  data_sin;
    logic [16:0] Data_Out;

    int n_checks;
    int n_pass;

    int tb_lut [32] = '{
        128, 153, 177, 199, 218, 234, 245, 253, 255, 253, 245, 234, 218, 199, 177, 153,
        128, 103, 79, 57, 38, 22, 11, 3, 1, 3, 11, 22, 38, 57, 79, 103
    };
    int tb_coef [8] = '{7, 31, 63, 127, 127, 63, 31, 7};
    int rel_sin [9] = '{128, 153, 177, 199, 218, 234, 245, 253, 255};

    int m_phase;
    int m_sin;
    int m_x [8];
    int m_out;
    int hist [0:127];

    fir_filter dut (
        .clock    (clock),
        .reset    (reset),
        .data_sin (data_sin),
        .Data_Out (Data_Out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_step();
        int acc;
        if (reset) begin
            m_phase = 0;
            m_sin   = 0;
            m_out   = 0;
            for (int i = 0; i < 8; i++) m_x[i] = 0;
        end else begin
            acc = 0;
            for (int i = 0; i < 8; i++) acc += tb_coef[i] * m_x[i];
            m_out = acc;
            for (int i = 7; i > 0; i--) m_x[i] = m_x[i-1];
            m_x[0]  = m_sin;
            m_sin   = tb_lut[m_phase];
            m_phase = (m_phase + 1) % 32;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic edge_checks(input int e);
        if (e <= 9) check("release_sin", {24'd0, data_sin}, rel_sin[e-1]);
        if (e == 33) check("wrap_sin", {24'd0, data_sin}, 128);
        if (e <= 2) check("fill_out_zero", {15'd0, Data_Out}, 0);
        if (e == 3) check("first_out", {15'd0, Data_Out}, 896);
        if (e == 4) check("second_out", {15'd0, Data_Out}, 5039);
        check("model_sin", {24'd0, data_sin}, m_sin);
        check("model_out", {15'd0, Data_Out}, m_out);
        check("out_max", {31'd0, (Data_Out <= 17'd116280)}, 1);
        check("sin_known", {31'd0, $isunknown(data_sin)}, 0);
        check("out_known", {31'd0, $isunknown(Data_Out)}, 0);
        if (e >= 42) check("period32", {15'd0, Data_Out}, hist[e-32]);
        hist[e] = int'(Data_Out);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;

        repeat (3) begin
            tick();
            check("reset_sin", {24'd0, data_sin}, 0);
            check("reset_out", {15'd0, Data_Out}, 0);
        end

        reset = 1'b0;
        for (int e = 1; e <= 49; e++) begin
            tick();
            edge_checks(e);
        end

        reset = 1'b1;
        tick();
        check("midrst_sin", {24'd0, data_sin}, 0);
        check("midrst_out", {15'd0, Data_Out}, 0);

        reset = 1'b0;
        for (int e = 1; e <= 100; e++) begin
            tick();
            edge_checks(e);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
